bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one single-port result BRAM between two requesters: port 0 (convolution engine write-back) and port 1 (UART dump reader).
- Grants at most one access per cycle and drives the registered BRAM command.
- Returns read data to the requester that issued the read, after a fixed latency.
- Round-robin fairness, plus a lock input so one requester can hold the port for a burst.

Parameters:
- ADDR_W, 32, width of BRAM address and requester addresses
- DATA_W, 8, width of BRAM data (signed samples)
- RD_LAT, 2, BRAM read latency: cycles from the edge sampling ena until dout is valid (1 or 2 only)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req0  input  1  port 0 requests an access this cycle
- lock0  input  1  port 0 keeps ownership while req0 stays high
- we0  input  1  port 0 write (1) / read (0)
- addr0  input  ADDR_W  port 0 address
- wdata0  input  DATA_W  port 0 write data
- gnt0  output  1  port 0 access accepted this cycle (combinational)
- rvalid0  output  1  port 0 read data valid, one-cycle pulse
- rdata0  output  DATA_W  port 0 read data (signed)
- req1, lock1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- ena  output  1  BRAM enable (registered)
- wea  output  1  BRAM write enable (registered)
- addr  output  ADDR_W  BRAM address (registered)
- din  output  DATA_W  BRAM write data (registered)
- dout  input  DATA_W  BRAM read data (signed)

Behaviour:
- Reset (async, active-high); all of these take effect immediately:
  - ena, wea, gnt0/1, rvalid0/1 = 0; addr, din, rdata0/1 = 0.
  - Priority pointer = port 0. Owner register = none.
  - Read pipeline cleared: in-flight reads are dropped and no rvalid is produced after reset deasserts.
- Grant is combinational from req0/req1, lock0/lock1, the owner register and the priority pointer. At most one of gnt0/gnt1 is high.
- Grant priority, highest first:
  - (a) Owner k has lockk=1 and reqk=1: grant k.
  - (b) Only one req high: grant it.
  - (c) Both high: grant the port named by the pointer.
  - (d) Neither high: no grant, ena=0 next cycle.
- Pointer update on a grant to port k:
  - lockk=0: pointer moves to the other port and owner is cleared.
  - lockk=1: owner becomes k and the pointer is unchanged.
  - Owner is also cleared whenever the owner's req is low in a cycle.
- Requester handshake: the requester holds req/we/addr/wdata stable until it sees gnt high. The access is consumed at the clock edge ending a gnt-high cycle. A requester may issue back-to-back accesses, one per granted cycle.
- Accept in cycle t means:
  - Cycle t+1: ena=1, wea=we, addr, din=wdata of the granted port.
  - Cycle t+1+RD_LAT, reads only: rvalidk=1 for exactly one cycle and rdatak=dout, captured in that cycle.
  - rdatak holds its value until the next read on that port.
  - Writes produce no rvalid.
- Read return uses a shift pipeline of depth RD_LAT+1 carrying {valid, port id}. Fully pipelined: one read issued per cycle gives one rvalid per cycle, in issue order.
- Simultaneous rvalid on both ports is impossible (one issue per cycle). The pipeline is never full-stalled; there is no backpressure on read data.
- A write followed by a read of the same address in the next granted cycle returns the written data. This relies on BRAM write-first or no-change mode with a single port; no bypass is implemented in this block.
- Starvation bound:
  - Without lock, a continuously requesting port is granted within 2 cycles.
  - With lock held by the other port, it waits until that lock or req drops.
- Data is passed through unmodified; no sign extension or width conversion.

Test Plan:
- Reset, then req0=1, we0=0, addr0=5 for one cycle with BRAM[5]=-3 (0xFD), RD_LAT=2 -> gnt0 high in cycle t, ena=1/addr=5 in t+1, rvalid0=1 and rdata0=0xFD in t+3, rvalid1 never high.
- req0 and req1 held high, lock=0, reads to addresses 10 and 20 -> grants alternate 0,1,0,1 starting with port 0; rvalid alternates with matching data; one BRAM access per cycle.
- Port 1 lock1=1, req1 held 4 cycles, req0 held high -> gnt1 for 4 consecutive cycles, gnt0 in the cycle after req1 drops.
- Port 0 writes 0x7F to address 3, then port 1 reads address 3 -> wea=1, din=0x7F on the BRAM; port 1 rvalid1 with rdata1=0x7F; no rvalid0 for the write.
- reset asserted one cycle after a read is granted -> ena, rvalid0/1 drop at once; after deassert no stale rvalid appears and the next grant with both ports requesting goes to port 0.
- Continuous port 1 reads to addresses 0..123 with no contention -> 124 rvalid1 pulses on consecutive cycles, data matches the BRAM contents in address order.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of a single-port result BRAM.
// Port 0 is the convolution write-back path, port 1 the UART dump reader.
// One access is granted per cycle, the BRAM command is registered, and read
// data is steered back to the issuing port through a {valid, port} shift
// pipeline that matches the BRAM read latency.
module bram_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 8,
  // Cycles from the edge sampling ena until dout is valid (1 or 2).
  parameter int unsigned RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset,

  // Port 0: convolution engine write-back
  input  logic                     req0,
  input  logic                     lock0,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        addr0,
  input  logic signed [DATA_W-1:0] wdata0,
  output logic                     gnt0,
  output logic                     rvalid0,
  output logic signed [DATA_W-1:0] rdata0,

  // Port 1: UART dump reader
  input  logic                     req1,
  input  logic                     lock1,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        addr1,
  input  logic signed [DATA_W-1:0] wdata1,
  output logic                     gnt1,
  output logic                     rvalid1,
  output logic signed [DATA_W-1:0] rdata1,

  // BRAM command (registered) and read data
  output logic                     ena,
  output logic                     wea,
  output logic [ADDR_W-1:0]        addr,
  output logic signed [DATA_W-1:0] din,
  input  logic signed [DATA_W-1:0] dout
);

  // Owner of a locked burst; OwnNone means plain round-robin applies.
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnP0   = 2'd1,
    OwnP1   = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  // Priority pointer: 0 means port 0 wins a contended cycle.
  logic   ptr_q, ptr_d;

  logic   gnt0_c, gnt1_c;
  logic   any_gnt;

  logic                     sel_we;
  logic [ADDR_W-1:0]        sel_addr;
  logic signed [DATA_W-1:0] sel_wdata;
  logic                     rd_issue;

  logic                     ena_q, wea_q;
  logic [ADDR_W-1:0]        addr_q;
  logic signed [DATA_W-1:0] din_q;

  // Read return pipeline: stage i is live i cycles after the command cycle.
  logic [RD_LAT:0]          pv_q;
  logic [RD_LAT:0]          pp_q;

  logic signed [DATA_W-1:0] rdata0_q, rdata1_q;
  logic                     rvalid0_c, rvalid1_c;

  // Grant decision: locked owner first, then a lone requester, then the pointer.
  // Reset forces both grants low immediately.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (reset) begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
    end else if ((owner_q == OwnP0) && lock0 && req0) begin
      gnt0_c = 1'b1;
    end else if ((owner_q == OwnP1) && lock1 && req1) begin
      gnt1_c = 1'b1;
    end else if (req0 && req1) begin
      if (ptr_q) begin
        gnt1_c = 1'b1;
      end else begin
        gnt0_c = 1'b1;
      end
    end else if (req0) begin
      gnt0_c = 1'b1;
    end else if (req1) begin
      gnt1_c = 1'b1;
    end
  end

  assign any_gnt = gnt0_c | gnt1_c;

  // Owner/pointer next state: an unlocked grant hands priority to the other
  // port, a locked grant claims ownership without moving the pointer.
  always_comb begin
    owner_d = owner_q;
    ptr_d   = ptr_q;
    // Ownership lapses as soon as the owner stops requesting.
    if ((owner_q == OwnP0) && !req0) begin
      owner_d = OwnNone;
    end
    if ((owner_q == OwnP1) && !req1) begin
      owner_d = OwnNone;
    end
    if (gnt0_c) begin
      if (lock0) begin
        owner_d = OwnP0;
      end else begin
        owner_d = OwnNone;
        ptr_d   = 1'b1;
      end
    end else if (gnt1_c) begin
      if (lock1) begin
        owner_d = OwnP1;
      end else begin
        owner_d = OwnNone;
        ptr_d   = 1'b0;
      end
    end
  end

  // Owner and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OwnNone;
      ptr_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Select the granted port's request fields for the BRAM command.
  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (gnt1_c) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  assign rd_issue = any_gnt & ~sel_we;

  // Registered BRAM command; addr/din only change on an accepted access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ena_q  <= 1'b0;
      wea_q  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      ena_q <= any_gnt;
      wea_q <= any_gnt & sel_we;
      if (any_gnt) begin
        addr_q <= sel_addr;
        din_q  <= sel_wdata;
      end
    end
  end

  // Read tag pipeline: stage 0 lines up with the ena cycle, the last stage
  // with the cycle dout carries the data. Reset drops in-flight reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q <= '0;
      pp_q <= '0;
    end else begin
      pv_q <= {pv_q[RD_LAT-1:0], rd_issue};
      pp_q <= {pp_q[RD_LAT-1:0], gnt1_c};
    end
  end

  assign rvalid0_c = pv_q[RD_LAT] & ~pp_q[RD_LAT];
  assign rvalid1_c = pv_q[RD_LAT] &  pp_q[RD_LAT];

  // Hold the last returned sample per port so rdata stays stable between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0_c) begin
        rdata0_q <= dout;
      end
      if (rvalid1_c) begin
        rdata1_q <= dout;
      end
    end
  end

  assign gnt0    = gnt0_c;
  assign gnt1    = gnt1_c;
  assign rvalid0 = rvalid0_c;
  assign rvalid1 = rvalid1_c;
  // dout is passed straight through in the valid cycle, then held.
  assign rdata0  = rvalid0_c ? dout : rdata0_q;
  assign rdata1  = rvalid1_c ? dout : rdata1_q;

  assign ena  = ena_q;
  assign wea  = wea_q;
  assign addr = addr_q;
  assign din  = din_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed vector table, reset and
// burst sequences, and randomized traffic against a cycle-indexed expectation
// schedule derived from the arbitration rules.
module tb_bram_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 2;
  localparam int NC = 4096;

  logic clk = 1'b0;
  logic reset;
  logic req0, lock0, we0, req1, lock1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic ena, wea;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din, dout;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ena(ena), .wea(wea), .addr(addr), .din(din), .dout(dout)
  );

  // BRAM model: single port, write-first, two-cycle read latency.
  logic [7:0] mem [256];
  logic [7:0] bram_p1;
  always @(posedge clk) begin
    if (ena) begin
      if (wea) mem[addr[7:0]] <= din;
      bram_p1 <= wea ? din : mem[addr[7:0]];
    end
    dout <= bram_p1;
  end

  // Reference state and expectation schedule, indexed by cycle number.
  logic [7:0] refmem [256];
  int  ptr, owner, cyc;
  bit  e_ena [NC];
  bit  e_we [NC];
  logic [31:0] e_addr [NC];
  logic [7:0]  e_din [NC];
  bit  e_rv [NC];
  bit  e_rvp [NC];
  logic [7:0]  e_rd [NC];
  logic [7:0]  last_rd0, last_rd1;
  int  n_checks, n_fail, g_last, rv1_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Which port the rules grant this cycle (-1 = none).
  function automatic int model_grant();
    if (owner == 0 && lock0 && req0) return 0;
    if (owner == 1 && lock1 && req1) return 1;
    if (req0 && req1) return ptr;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic clear_model();
    ptr = 0;
    owner = -1;
    last_rd0 = '0;
    last_rd1 = '0;
    for (int i = cyc; i < NC; i++) begin
      e_ena[i] = 0; e_rv[i] = 0;
    end
  endtask

  // One cycle: check at negedge, then advance the model at posedge.
  task automatic step(input int tbl_g);
    int g, act_g, nc;
    logic [7:0] x0, x1;
    logic k_we;
    logic [31:0] k_addr;
    logic [7:0] k_wd;
    bit k_lock;
    @(negedge clk);
    g = model_grant();
    act_g = gnt0 ? 0 : (gnt1 ? 1 : -1);
    chk("gnt0", gnt0, g == 0);
    chk("gnt1", gnt1, g == 1);
    if (tbl_g != -2) chk("table_gnt", act_g, tbl_g);
    chk("ena", ena, e_ena[cyc]);
    if (e_ena[cyc]) begin
      chk("wea", wea, e_we[cyc]);
      chk("addr", addr, e_addr[cyc]);
      chk("din", din, e_din[cyc]);
    end
    chk("rvalid0", rvalid0, e_rv[cyc] && !e_rvp[cyc]);
    chk("rvalid1", rvalid1, e_rv[cyc] && e_rvp[cyc]);
    x0 = (e_rv[cyc] && !e_rvp[cyc]) ? e_rd[cyc] : last_rd0;
    x1 = (e_rv[cyc] && e_rvp[cyc]) ? e_rd[cyc] : last_rd1;
    chk("rdata0", rdata0, x0);
    chk("rdata1", rdata1, x1);
    last_rd0 = x0;
    last_rd1 = x1;
    if (rvalid1) rv1_cnt++;
    @(posedge clk);
    if (owner == 0 && !req0) owner = -1;
    if (owner == 1 && !req1) owner = -1;
    if (g >= 0) begin
      k_we   = (g == 1) ? we1 : we0;
      k_addr = (g == 1) ? addr1 : addr0;
      k_wd   = (g == 1) ? wdata1 : wdata0;
      k_lock = (g == 1) ? lock1 : lock0;
      nc = cyc + 1;
      e_ena[nc] = 1; e_we[nc] = k_we; e_addr[nc] = k_addr; e_din[nc] = k_wd;
      if (k_we) begin
        refmem[k_addr[7:0]] = k_wd;
      end else begin
        e_rv[nc + RD_LAT] = 1;
        e_rvp[nc + RD_LAT] = (g == 1);
        e_rd[nc + RD_LAT] = refmem[k_addr[7:0]];
      end
      if (k_lock) owner = g;
      else begin
        owner = -1;
        ptr = 1 - g;
      end
    end
    g_last = g;
    cyc++;
    #1;
  endtask

  typedef struct {
    bit r0; bit l0; bit w0; int a0; logic [7:0] d0;
    bit r1; bit l1; bit w1; int a1; logic [7:0] d1;
    int g;
  } vec_t;

  function automatic vec_t mk(bit r0, bit l0, bit w0, int a0, logic [7:0] d0,
                              bit r1, bit l1, bit w1, int a1, logic [7:0] d1, int g);
    vec_t v;
    v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.g = g;
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; rv1_cnt = 0; g_last = -1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      refmem[i] = mem[i];
    end
    mem[5] = 8'hFD; refmem[5] = 8'hFD;
    mem[3] = 8'h11; refmem[3] = 8'h11;

    // Directed table: single read, alternation, lock burst, write then read.
    tbl[0]  = mk(1,0,0, 5,8'h00, 0,0,0, 0,8'h00,  0);
    tbl[1]  = mk(0,0,0, 0,8'h00, 0,0,0, 0,8'h00, -1);
    tbl[2]  = mk(0,0,0, 0,8'h00, 0,0,0, 0,8'h00, -1);
    tbl[3]  = mk(0,0,0, 0,8'h00, 0,0,0, 0,8'h00, -1);
    tbl[4]  = mk(0,0,0, 0,8'h00, 1,0,0,20,8'h00,  1);
    tbl[5]  = mk(1,0,0,10,8'h00, 1,0,0,20,8'h00,  0);
    tbl[6]  = mk(1,0,0,10,8'h00, 1,0,0,20,8'h00,  1);
    tbl[7]  = mk(1,0,0,10,8'h00, 1,0,0,20,8'h00,  0);
    tbl[8]  = mk(1,0,0,10,8'h00, 1,0,0,20,8'h00,  1);
    tbl[9]  = mk(0,0,0, 0,8'h00, 1,1,0,20,8'h00,  1);
    tbl[10] = mk(1,0,0,10,8'h00, 1,1,0,20,8'h00,  1);
    tbl[11] = mk(1,0,0,10,8'h00, 1,1,0,20,8'h00,  1);
    tbl[12] = mk(1,0,0,10,8'h00, 1,1,0,20,8'h00,  1);
    tbl[13] = mk(1,0,0,10,8'h00, 0,0,0, 0,8'h00,  0);
    tbl[14] = mk(1,0,1, 3,8'h7F, 0,0,0, 0,8'h00,  0);
    tbl[15] = mk(0,0,0, 0,8'h00, 1,0,0, 3,8'h00,  1);
    for (int i = 16; i < 20; i++) tbl[i] = mk(0,0,0,0,8'h00, 0,0,0,0,8'h00, -1);

    // Reset state, with both ports requesting to show grants are held off.
    reset = 1'b1;
    req0 = 1; lock0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 1; lock1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    #3;
    chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
    chk("rst_ena", ena, 0);   chk("rst_wea", wea, 0);
    chk("rst_addr", addr, 0); chk("rst_din", din, 0);
    chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);   chk("rst_rdata1", rdata1, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
    clear_model();

    for (int i = 0; i < 20; i++) begin
      req0 = tbl[i].r0; lock0 = tbl[i].l0; we0 = tbl[i].w0;
      addr0 = 32'(tbl[i].a0); wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; lock1 = tbl[i].l1; we1 = tbl[i].w1;
      addr1 = 32'(tbl[i].a1); wdata1 = tbl[i].d1;
      step(tbl[i].g);
    end
    chk("write_reached_bram", mem[3], 8'h7F);

    // Randomized traffic; a requester holds its fields until granted.
    for (int n = 0; n < 400; n++) begin
      if (!(req0 && g_last != 0)) begin
        req0 = ($urandom_range(0, 99) < 60); lock0 = ($urandom_range(0, 3) == 0);
        we0 = ($urandom_range(0, 2) == 0); addr0 = 32'($urandom_range(0, 15));
        wdata0 = 8'($urandom);
      end
      if (!(req1 && g_last != 1)) begin
        req1 = ($urandom_range(0, 99) < 60); lock1 = ($urandom_range(0, 3) == 0);
        we1 = ($urandom_range(0, 2) == 0); addr1 = 32'($urandom_range(0, 15));
        wdata1 = 8'($urandom);
      end
      step(-2);
    end
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    for (int i = 0; i < 5; i++) step(-2);

    // Reset right after a read is granted: command and pipeline drop at once.
    req0 = 1; we0 = 0; addr0 = 32'd7;
    step(0);
    req1 = 1; we1 = 0; addr1 = 32'd9;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ena", ena, 0);
    chk("mid_rst_gnt0", gnt0, 0);
    chk("mid_rst_gnt1", gnt1, 0);
    chk("mid_rst_rvalid0", rvalid0, 0);
    chk("mid_rst_rvalid1", rvalid1, 0);
    clear_model();
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1 reset = 1'b0;
    step(0);
    req0 = 0;
    step(1);
    req1 = 0;
    for (int i = 0; i < 5; i++) step(-1);

    // Uncontended port 1 burst over addresses 0..123.
    rv1_cnt = 0;
    req1 = 1; we1 = 0;
    for (int i = 0; i < 124; i++) begin
      addr1 = 32'(i);
      step(1);
    end
    req1 = 0;
    for (int i = 0; i < 4; i++) step(-1);
    chk("burst_rvalid1_count", 32'(rv1_cnt), 32'd124);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
